// File: rtl/dm_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: one instance per port.
//   req       request valid, held with its fields until gnt
//   we        1 = store, 0 = load
//   size      0 byte, 1 half, 2 word (3 is illegal)
//   sext      load extension: 1 sign, 0 zero
//   addr      byte address
//   wdata     store data, right-justified
//   gnt       combinational accept; request consumed when req & gnt
//   rsp_valid single-cycle response pulse
//   rdata     load result (0 for stores and errors)
//   err       misaligned / out-of-range / illegal size
// master = requester (CPU MEM stage or debug/DMA), slave = arbiter.
interface dm_arbiter_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, size, sext, addr, wdata,
        input  gnt, rsp_valid, rdata, err
    );

    modport slave (
        input  req, we, size, sext, addr, wdata,
        output gnt, rsp_valid, rdata, err
    );
endinterface

// File: rtl/dm_arbiter.sv
// Shares a single-ported data memory (registered read, per-byte write enables)
// between port 0 (CPU MEM stage) and port 1 (debug/DMA). Formats stores into
// replicated lane data plus byte enables, aligns/extends loads, flags bad
// accesses and returns one response per accepted request.
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous, active-low reset
//   p0, p1          requester buses (dm_arbiter_if.slave)
//   dm_addr         word-aligned memory address (driven only in ISSUE)
//   dm_we           memory write enable
//   dm_win          lane-replicated write data
//   dm_wbyte_enable byte-lane enables
//   dm_dout         memory read data, valid the cycle after the address
//   busy            access in progress (state != IDLE)
module dm_arbiter #(
    parameter int ADDR_BITS  = 12,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    dm_arbiter_if.slave  p0,
    dm_arbiter_if.slave  p1,
    output logic [31:0]  dm_addr,
    output logic         dm_we,
    output logic [31:0]  dm_win,
    output logic [3:0]   dm_wbyte_enable,
    input  logic [31:0]  dm_dout,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t      state_reg, state_next;
    logic        port_reg;
    logic        last_reg;   // port granted most recently (1 after reset so port 0 wins first)
    logic        we_reg, sext_reg, err_reg;
    logic [1:0]  size_reg;
    logic [31:0] addr_reg, wdata_reg, rdata_reg;

    logic        gnt0, gnt1;
    logic        sel_we, sel_sext;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr, sel_wdata;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic        store_ok;

    function automatic logic access_err(input logic [1:0] size, input logic [31:0] addr);
        logic e;
        e = ((addr >> ADDR_BITS) != 32'd0);
        case (size)
            2'd0:    e = e;
            2'd1:    e = e | addr[0];
            2'd2:    e = e | (addr[1:0] != 2'b00);
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    // Grant only in IDLE and never while reset is held; on contention the
    // port that did not win last time is served (or port 0 with fixed priority).
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst && state_reg == IDLE) begin
            if (p0.req && p1.req) begin
                if (FIXED_PRIO || last_reg) gnt0 = 1'b1;
                else                        gnt1 = 1'b1;
            end else begin
                gnt0 = p0.req;
                gnt1 = p1.req;
            end
        end
    end

    assign p0.gnt = gnt0;
    assign p1.gnt = gnt1;

    assign sel_we    = gnt1 ? p1.we    : p0.we;
    assign sel_sext  = gnt1 ? p1.sext  : p0.sext;
    assign sel_size  = gnt1 ? p1.size  : p0.size;
    assign sel_addr  = gnt1 ? p1.addr  : p0.addr;
    assign sel_wdata = gnt1 ? p1.wdata : p0.wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            port_reg  <= 1'b0;
            we_reg    <= 1'b0;
            sext_reg  <= 1'b0;
            err_reg   <= 1'b0;
            size_reg  <= 2'd0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            rdata_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (gnt0 || gnt1) begin
                port_reg  <= gnt1;
                last_reg  <= gnt1;
                we_reg    <= sel_we;
                sext_reg  <= sel_sext;
                size_reg  <= sel_size;
                addr_reg  <= sel_addr;
                wdata_reg <= sel_wdata;
                err_reg   <= access_err(sel_size, sel_addr);
            end
            if (state_reg == CAPTURE) rdata_reg <= load_data;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (gnt0 || gnt1) state_next = ISSUE;
            ISSUE:   state_next = (we_reg || err_reg) ? RESP : CAPTURE;
            CAPTURE: state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory side: everything is zero outside ISSUE; errored stores never write.
    assign store_ok = we_reg && !err_reg;

    always_comb begin
        dm_addr         = 32'd0;
        dm_we           = 1'b0;
        dm_win          = 32'd0;
        dm_wbyte_enable = 4'b0000;
        if (state_reg == ISSUE) begin
            dm_addr = {addr_reg[31:2], 2'b00};
            if (store_ok) begin
                dm_we = 1'b1;
                case (size_reg)
                    2'd0: begin
                        dm_wbyte_enable = 4'b0001 << addr_reg[1:0];
                        dm_win          = {4{wdata_reg[7:0]}};
                    end
                    2'd1: begin
                        dm_wbyte_enable = addr_reg[1] ? 4'b1100 : 4'b0011;
                        dm_win          = {2{wdata_reg[15:0]}};
                    end
                    default: begin
                        dm_wbyte_enable = 4'b1111;
                        dm_win          = wdata_reg;
                    end
                endcase
            end
        end
    end

    // Load alignment: pick the addressed lane, then extend.
    always_comb begin
        case (addr_reg[1:0])
            2'd0:    load_byte = dm_dout[7:0];
            2'd1:    load_byte = dm_dout[15:8];
            2'd2:    load_byte = dm_dout[23:16];
            default: load_byte = dm_dout[31:24];
        endcase
        load_half = addr_reg[1] ? dm_dout[31:16] : dm_dout[15:0];
        case (size_reg)
            2'd0:    load_data = {{24{sext_reg & load_byte[7]}}, load_byte};
            2'd1:    load_data = {{16{sext_reg & load_half[15]}}, load_half};
            default: load_data = dm_dout;
        endcase
    end

    assign p0.rsp_valid = (state_reg == RESP) && !port_reg;
    assign p1.rsp_valid = (state_reg == RESP) &&  port_reg;
    assign p0.err       = p0.rsp_valid && err_reg;
    assign p1.err       = p1.rsp_valid && err_reg;
    assign p0.rdata     = (p0.rsp_valid && !we_reg && !err_reg) ? rdata_reg : 32'd0;
    assign p1.rdata     = (p1.rsp_valid && !we_reg && !err_reg) ? rdata_reg : 32'd0;

    assign busy = (state_reg != IDLE);
endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;
    logic        clk;
    logic        rst;
    logic [31:0] dm_addr, dm_win, dm_dout;
    logic        dm_we, busy;
    logic [3:0]  dm_wbyte_enable;
    logic [31:0] fp_addr, fp_win, fp_dout;
    logic        fp_we, fp_busy;
    logic [3:0]  fp_be;
    logic [31:0] mem [0:1023];
    int checks = 0;
    int errors = 0;

    dm_arbiter_if p0();
    dm_arbiter_if p1();
    dm_arbiter_if q0();
    dm_arbiter_if q1();

    dm_arbiter #(.ADDR_BITS(12), .FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst), .p0(p0), .p1(p1),
        .dm_addr(dm_addr), .dm_we(dm_we), .dm_win(dm_win),
        .dm_wbyte_enable(dm_wbyte_enable), .dm_dout(dm_dout), .busy(busy)
    );

    dm_arbiter #(.ADDR_BITS(12), .FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst), .p0(q0), .p1(q1),
        .dm_addr(fp_addr), .dm_we(fp_we), .dm_win(fp_win),
        .dm_wbyte_enable(fp_be), .dm_dout(fp_dout), .busy(fp_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory model: byte-enabled write, one-cycle registered read.
    initial for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    always @(posedge clk) begin
        if (dm_we)
            for (int i = 0; i < 4; i++)
                if (dm_wbyte_enable[i]) mem[dm_addr[11:2]][8*i +: 8] <= dm_win[8*i +: 8];
        dm_dout <= mem[dm_addr[11:2]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int port, input logic we, input logic [1:0] size,
                           input logic sext, input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            p0.we = we; p0.size = size; p0.sext = sext; p0.addr = addr; p0.wdata = wdata; p0.req = 1'b1;
        end else begin
            p1.we = we; p1.size = size; p1.sext = sext; p1.addr = addr; p1.wdata = wdata; p1.req = 1'b1;
        end
    endtask

    task automatic do_access(input int port, input logic we, input logic [1:0] size,
                             input logic sext, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] exp_rdata, input logic exp_err,
                             input logic [3:0] exp_be, input logic [31:0] exp_win, input string tag);
        int n;
        logic exp_dmwe;
        logic [31:0] rd;
        exp_dmwe = we && !exp_err;
        set_req(port, we, size, sext, addr, wdata);
        n = 0;
        @(negedge clk);
        while (!(port == 1 ? p1.gnt : p0.gnt) && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_gnt"}, {31'd0, (port == 1 ? p1.gnt : p0.gnt)}, 32'd1);
        @(posedge clk); #1;
        if (port == 1) p1.req = 1'b0; else p0.req = 1'b0;
        @(negedge clk);
        chk({tag, "_addr"}, dm_addr, addr & 32'hFFFF_FFFC);
        chk({tag, "_we"}, {31'd0, dm_we}, {31'd0, exp_dmwe});
        if (we) chk({tag, "_be"}, {28'd0, dm_wbyte_enable}, {28'd0, exp_be});
        if (exp_dmwe) chk({tag, "_win"}, dm_win, exp_win);
        if (!we && !exp_err) begin
            @(negedge clk);
            chk({tag, "_early"}, {31'd0, (port == 1 ? p1.rsp_valid : p0.rsp_valid)}, 32'd0);
        end
        @(negedge clk);
        rd = (port == 1) ? p1.rdata : p0.rdata;
        chk({tag, "_rsp"}, {31'd0, (port == 1 ? p1.rsp_valid : p0.rsp_valid)}, 32'd1);
        chk({tag, "_err"}, {31'd0, (port == 1 ? p1.err : p0.err)}, {31'd0, exp_err});
        chk({tag, "_rdata"}, rd, exp_rdata);
        $display("txn %s port=%0d we=%0d size=%0d addr=%h rdata=%h err=%0d",
                 tag, port, we, size, addr, rd, (port == 1 ? p1.err : p0.err));
        @(posedge clk); #1;
    endtask

    int na, nb;
    int g_rr [4];
    int g_fp [4];

    initial begin
        rst = 1'b0;
        fp_dout = 32'd0;
        p0.req = 0; p0.we = 0; p0.size = 0; p0.sext = 0; p0.addr = 0; p0.wdata = 0;
        p1.req = 0; p1.we = 0; p1.size = 0; p1.sext = 0; p1.addr = 0; p1.wdata = 0;
        q0.req = 0; q0.we = 1; q0.size = 2; q0.sext = 0; q0.addr = 32'h10; q0.wdata = 0;
        q1.req = 0; q1.we = 1; q1.size = 2; q1.sext = 0; q1.addr = 32'h14; q1.wdata = 0;

        // Reset state: no grant even with a request pending
        set_req(0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_gnt", {31'd0, p0.gnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_we", {31'd0, dm_we}, 32'd0);
        chk("rst_rsp", {31'd0, p0.rsp_valid}, 32'd0);
        p0.req = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // Stores and loads with formatting
        do_access(0, 1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 32'hDEADBEEF, "st_word");
        do_access(0, 0, 2'd0, 1, 32'h103, 32'h0, 32'hFFFFFFDE, 0, 4'b0000, 32'h0, "ld_b_s");
        do_access(0, 0, 2'd0, 0, 32'h103, 32'h0, 32'h000000DE, 0, 4'b0000, 32'h0, "ld_b_u");
        do_access(1, 1, 2'd1, 0, 32'h102, 32'h00001234, 32'h0, 0, 4'b1100, 32'h12341234, "st_half");
        do_access(0, 0, 2'd2, 0, 32'h100, 32'h0, 32'h1234BEEF, 0, 4'b0000, 32'h0, "ld_word");
        do_access(1, 0, 2'd0, 1, 32'h101, 32'h0, 32'hFFFFFFBE, 0, 4'b0000, 32'h0, "ld_b101");
        do_access(1, 0, 2'd1, 1, 32'h100, 32'h0, 32'hFFFFBEEF, 0, 4'b0000, 32'h0, "ld_h_s");
        do_access(0, 0, 2'd1, 1, 32'h102, 32'h0, 32'h00001234, 0, 4'b0000, 32'h0, "ld_h_hi");
        do_access(0, 1, 2'd0, 0, 32'h105, 32'hFFFFFFA5, 32'h0, 0, 4'b0010, 32'hA5A5A5A5, "st_byte");
        do_access(1, 0, 2'd2, 0, 32'h104, 32'h0, 32'h0000A500, 0, 4'b0000, 32'h0, "ld_w104");

        // Errors: misaligned, out of range, illegal size
        do_access(1, 0, 2'd2, 0, 32'h102, 32'h0, 32'h0, 1, 4'b0000, 32'h0, "err_misal");
        do_access(0, 1, 2'd2, 0, 32'h2000, 32'hCAFEF00D, 32'h0, 1, 4'b0000, 32'h0, "err_range");
        do_access(1, 0, 2'd3, 0, 32'h0, 32'h0, 32'h0, 1, 4'b0000, 32'h0, "err_size");
        do_access(0, 1, 2'd1, 0, 32'h101, 32'h5555, 32'h0, 1, 4'b0000, 32'h0, "err_half");

        // Reset during ISSUE of a store
        set_req(0, 1'b1, 2'd2, 1'b0, 32'h200, 32'h11111111);
        na = 0;
        @(negedge clk);
        while (!p0.gnt && na < 10) begin na++; @(negedge clk); end
        chk("rst6_gnt", {31'd0, p0.gnt}, 32'd1);
        @(posedge clk); #1 p0.req = 1'b0;
        @(negedge clk);
        chk("rst6_pre_we", {31'd0, dm_we}, 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("rst6_we", {31'd0, dm_we}, 32'd0);
        chk("rst6_be", {28'd0, dm_wbyte_enable}, 32'd0);
        chk("rst6_busy", {31'd0, busy}, 32'd0);
        set_req(0, 1'b1, 2'd2, 1'b0, 32'h208, 32'hAAAA0000);
        set_req(1, 1'b1, 2'd2, 1'b0, 32'h20C, 32'hBBBB1111);
        q0.req = 1'b1;
        q1.req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst6_norsp", {30'd0, p0.rsp_valid, p1.rsp_valid}, 32'd0);
        end
        @(posedge clk); #1 rst = 1'b1;

        // Both ports held: round robin alternates, fixed priority always port 0
        na = 0; nb = 0;
        for (int i = 0; i < 40 && (na < 4 || nb < 4); i++) begin
            @(negedge clk);
            if (p0.gnt && p1.gnt) chk("rr_onehot", 32'd1, 32'd0);
            if (na < 4 && (p0.gnt || p1.gnt)) begin g_rr[na] = p1.gnt ? 1 : 0; na++; end
            if (nb < 4 && (q0.gnt || q1.gnt)) begin g_fp[nb] = q1.gnt ? 1 : 0; nb++; end
        end
        chk("rr_count", na, 4);
        chk("fp_count", nb, 4);
        chk("rr_g0", g_rr[0], 0);
        chk("rr_g1", g_rr[1], 1);
        chk("rr_g2", g_rr[2], 0);
        chk("rr_g3", g_rr[3], 1);
        for (int k = 0; k < 4; k++) chk($sformatf("fp_g%0d", k), g_fp[k], 0);
        $display("txn rr grants=%0d%0d%0d%0d fixed grants=%0d%0d%0d%0d",
                 g_rr[0], g_rr[1], g_rr[2], g_rr[3], g_fp[0], g_fp[1], g_fp[2], g_fp[3]);
        @(posedge clk); #1;
        p0.req = 1'b0; p1.req = 1'b0; q0.req = 1'b0; q1.req = 1'b0;
        for (int n = 0; n < 10 && (busy || fp_busy); n++) @(negedge clk);
        chk("drain_busy", {30'd0, busy, fp_busy}, 32'd0);
        @(posedge clk); #1;

        // The store aborted by reset never reached memory; round-robin stores did
        do_access(0, 0, 2'd2, 0, 32'h200, 32'h0, 32'h00000000, 0, 4'b0000, 32'h0, "ld_aborted");
        do_access(1, 0, 2'd2, 0, 32'h208, 32'h0, 32'hAAAA0000, 0, 4'b0000, 32'h0, "ld_rr_p0");
        do_access(0, 0, 2'd2, 0, 32'h20C, 32'h0, 32'hBBBB1111, 0, 4'b0000, 32'h0, "ld_rr_p1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
